// File: rtl/io_pkg.sv
// Shared types and register addresses for the push-button input peripheral.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_REL
    } btn_state_e;

    localparam logic [11:0] ADDR_BTN_LVL  = 12'h910;
    localparam logic [11:0] ADDR_BTN_EVT  = 12'h914;
    localparam logic [11:0] ADDR_BTN_CFG  = 12'h918;
    localparam logic [11:0] ADDR_BTN_MASK = 12'h91C;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, saturating debounce counter and
// press/hold/release state machine with a single-cycle press pulse.
module btn_debounce
    import io_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             btn_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             level_o,
    output logic             press_evt_o
);

    logic             r_meta;
    logic             r_sync;
    btn_state_e       r_state;
    btn_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_period;
    logic             w_expired;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_meta  <= btn_i;
            r_sync  <= r_meta;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A zero period behaves as one; the compare follows live CFG writes.
    assign w_period  = (period_i == '0) ? CNT_W'(1) : period_i;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_expired = (r_cnt >= w_period);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        press_evt_o  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync) begin
                    w_state_next = DB_PRESS;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            DB_PRESS: begin
                if (!r_sync) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (w_expired) begin
                    w_state_next = HELD;
                    w_cnt_next   = '0;
                    press_evt_o  = 1'b1;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            HELD: begin
                if (!r_sync) begin
                    w_state_next = DB_REL;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            DB_REL: begin
                if (r_sync) begin
                    w_state_next = HELD;
                    w_cnt_next   = '0;
                end else if (w_expired) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign level_o = (r_state == HELD) || (r_state == DB_REL);

endmodule

// File: rtl/btn_event_ctrl.sv
// Memory-mapped button controller: per-button debouncers plus LVL/EVT/CFG/MASK
// registers at 0x910-0x91C and a registered level interrupt.
module btn_event_ctrl
    import io_pkg::*;
#(
    parameter int               NUM_BTN  = 4,
    parameter int               CNT_W    = 20,
    parameter logic [CNT_W-1:0] DB_RESET = 20'd50000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_BTN-1:0] io_button_i,
    input  logic [11:0]        addr_i,
    input  logic               wr_en_i,
    input  logic [31:0]        st_data_i,
    output logic [31:0]        ld_data_o,
    output logic               irq_o
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] r_evt;
    logic [NUM_BTN-1:0] r_mask;
    logic [CNT_W-1:0]   r_cfg;
    logic               r_irq;
    logic [NUM_BTN-1:0] w_evt_clr;
    logic               w_wr_evt;
    logic               w_wr_cfg;
    logic               w_wr_mask;
    logic               w_unused_bits;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_debounce #(
            .CNT_W(CNT_W)
        ) u_debounce (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .btn_i       (io_button_i[gi]),
            .period_i    (r_cfg),
            .level_o     (w_level[gi]),
            .press_evt_o (w_press[gi])
        );
    end

    assign w_wr_evt  = wr_en_i && (addr_i == ADDR_BTN_EVT);
    assign w_wr_cfg  = wr_en_i && (addr_i == ADDR_BTN_CFG);
    assign w_wr_mask = wr_en_i && (addr_i == ADDR_BTN_MASK);
    assign w_evt_clr = w_wr_evt ? st_data_i[NUM_BTN-1:0] : '0;
    assign w_unused_bits = &{1'b0, st_data_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_evt  <= '0;
            r_mask <= '0;
            r_cfg  <= DB_RESET;
            r_irq  <= 1'b0;
        end else begin
            // A press landing with a W1C store keeps its bit: set wins.
            r_evt <= (r_evt & ~w_evt_clr) | w_press;
            if (w_wr_mask) begin
                r_mask <= st_data_i[NUM_BTN-1:0];
            end
            if (w_wr_cfg) begin
                r_cfg <= st_data_i[CNT_W-1:0];
            end
            r_irq <= |(r_evt & r_mask);
        end
    end

    always_comb begin
        ld_data_o = '0;
        case (addr_i)
            ADDR_BTN_LVL:  ld_data_o[NUM_BTN-1:0] = w_level;
            ADDR_BTN_EVT:  ld_data_o[NUM_BTN-1:0] = r_evt;
            ADDR_BTN_CFG:  ld_data_o[CNT_W-1:0]   = r_cfg;
            ADDR_BTN_MASK: ld_data_o[NUM_BTN-1:0] = r_mask;
            default:       ld_data_o = '0;
        endcase
    end

    assign irq_o = r_irq;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: expectations queued as stimulus is driven,
// popped and checked against ld_data_o / irq_o.
module tb_btn_event_ctrl;

    localparam logic [11:0] A_LVL  = 12'h910;
    localparam logic [11:0] A_EVT  = 12'h914;
    localparam logic [11:0] A_CFG  = 12'h918;
    localparam logic [11:0] A_MASK = 12'h91C;

    logic        clk;
    logic        rst_n;
    logic [3:0]  btn;
    logic [11:0] addr;
    logic        wr_en;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];

    btn_event_ctrl #(
        .NUM_BTN (4),
        .CNT_W   (20),
        .DB_RESET(20'd50000)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .io_button_i(btn),
        .addr_i     (addr),
        .wr_en_i    (wr_en),
        .st_data_i  (st_data),
        .ld_data_o  (ld_data),
        .irq_o      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h required none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] v);
        addr = a;
        push_exp(tag, v);
        #1;
        $display("read  %-14s addr=%h data=%h exp=%h", tag, a, ld_data, v);
        compare(ld_data);
    endtask

    task automatic irq_chk(input string tag, input logic v);
        push_exp(tag, {31'd0, v});
        $display("irq   %-14s irq=%b exp=%b", tag, irq, v);
        compare({31'd0, irq});
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        addr    = a;
        st_data = d;
        wr_en   = 1'b1;
        $display("write addr=%h data=%h", a, d);
        tick(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        btn     = 4'h0;
        addr    = 12'h000;
        wr_en   = 1'b0;
        st_data = 32'd0;

        // Reset with button held high
        tick(2);
        btn = 4'h1;
        tick(3);
        rd_chk("rst_lvl",  A_LVL,  32'd0);
        rd_chk("rst_evt",  A_EVT,  32'd0);
        rd_chk("rst_cfg",  A_CFG,  32'd50000);
        rd_chk("rst_mask", A_MASK, 32'd0);
        irq_chk("rst_irq", 1'b0);
        rst_n = 1'b1;
        wr(A_CFG, 32'd4);                 // edge 1
        tick(5);                          // edge 6
        rd_chk("pwr_lvl_e6", A_LVL, 32'd0);
        tick(1);                          // edge 7
        rd_chk("pwr_lvl_e7", A_LVL, 32'd1);
        rd_chk("pwr_evt_e7", A_EVT, 32'd1);

        // Release: DB_REL keeps LVL high until edge 7
        btn = 4'h0;
        tick(6);
        rd_chk("rel_lvl_e6", A_LVL, 32'd1);
        tick(1);
        rd_chk("rel_lvl_e7", A_LVL, 32'd0);
        wr(A_EVT, 32'd1);
        rd_chk("evt_clr", A_EVT, 32'd0);
        tick(2);

        // Bounce: high 3, low 1, high 10; event at edge 11
        for (int k = 1; k <= 14; k++) begin
            btn[0] = (k == 4) ? 1'b0 : 1'b1;
            tick(1);
            rd_chk($sformatf("bounce_e%0d", k), A_EVT, (k >= 11) ? 32'd1 : 32'd0);
        end
        wr(A_EVT, 32'd1);
        tick(5);
        rd_chk("bounce_single", A_EVT, 32'd0);
        btn = 4'h0;
        tick(10);
        rd_chk("bounce_rel_evt", A_EVT, 32'd0);
        rd_chk("bounce_rel_lvl", A_LVL, 32'd0);

        // Interrupt path
        wr(A_MASK, 32'd1);
        btn = 4'h1;
        tick(6);
        rd_chk("irq_evt_e6", A_EVT, 32'd0);
        tick(1);
        rd_chk("irq_evt_e7", A_EVT, 32'd1);
        irq_chk("irq_e7", 1'b0);
        tick(1);
        irq_chk("irq_e8", 1'b1);
        wr(A_EVT, 32'd0);
        rd_chk("w0_evt", A_EVT, 32'd1);
        irq_chk("w0_irq", 1'b1);
        wr(A_EVT, 32'd1);
        rd_chk("w1c_evt", A_EVT, 32'd0);
        irq_chk("w1c_irq_same", 1'b1);
        tick(1);
        irq_chk("w1c_irq_next", 1'b0);
        btn = 4'h0;
        tick(10);

        // W1C store landing on the same edge as the press event
        btn = 4'h1;
        tick(6);
        wr(A_EVT, 32'd1);                 // edge 7
        rd_chk("set_wins_evt", A_EVT, 32'd1);
        tick(1);
        irq_chk("set_wins_irq", 1'b1);
        wr(A_EVT, 32'd1);
        tick(1);
        irq_chk("set_wins_clr", 1'b0);
        btn = 4'h0;
        tick(10);

        // CFG shrunk mid-count
        wr(A_CFG, 32'd100);
        btn = 4'h1;
        tick(52);                         // cnt = 50
        rd_chk("cfg_lvl_cnt50", A_LVL, 32'd0);
        wr(A_CFG, 32'd10);                // edge 53
        rd_chk("cfg_lvl_store", A_LVL, 32'd0);
        tick(1);
        rd_chk("cfg_lvl_next", A_LVL, 32'd1);
        rd_chk("cfg_evt_next", A_EVT, 32'd1);
        wr(A_EVT, 32'd1);
        btn = 4'h0;
        tick(20);

        // Unmapped reads, writes to LVL, upper CFG bits
        rd_chk("rd_900", 12'h900, 32'd0);
        rd_chk("rd_920", 12'h920, 32'd0);
        rd_chk("rd_913", 12'h913, 32'd0);
        wr(A_LVL, 32'hFFFF_FFFF);
        rd_chk("lvl_ro", A_LVL, 32'd0);
        rd_chk("cfg_keep", A_CFG, 32'd10);
        rd_chk("mask_keep", A_MASK, 32'd1);
        wr(A_CFG, 32'hFFF0_0004);
        rd_chk("cfg_upper", A_CFG, 32'd4);

        // Asynchronous reset while button0 is in DB_PRESS
        wr(A_MASK, 32'd3);
        btn = 4'h2;
        tick(8);
        rd_chk("pre_rst_evt", A_EVT, 32'd2);
        irq_chk("pre_rst_irq", 1'b1);
        btn = 4'h3;
        tick(4);
        rd_chk("pre_rst_lvl", A_LVL, 32'd2);
        rst_n = 1'b0;
        #1;
        rd_chk("arst_lvl",  A_LVL,  32'd0);
        rd_chk("arst_evt",  A_EVT,  32'd0);
        rd_chk("arst_cfg",  A_CFG,  32'd50000);
        rd_chk("arst_mask", A_MASK, 32'd0);
        irq_chk("arst_irq", 1'b0);
        btn = 4'h0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        rd_chk("post_rst_lvl", A_LVL, 32'd0);
        rd_chk("post_rst_evt", A_EVT, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
